// File: rtl/sha_result_scanner.sv
`default_nettype none
// ============================================================================
// Module   : sha_result_scanner
// Brief    : Captures a batch of NUM_SHABLOCKS finished SHA digests plus the
//            batch base nonce, scans them in index order against the target,
//            and reports the first winning nonce (or a miss) with one done
//            pulse.
// Options  : SCANNER_PIPE_CMP_EN - register the 256-bit compare result for
//            one extra stage (each result arrives one edge later).
// Revision : 1.0 - initial release
// ============================================================================
module sha_result_scanner #(
  parameter int NUM_SHABLOCKS      = 10,
  parameter int LOG2_NUM_SHABLOCKS = 4,
  parameter int HASH_WIDTH         = 256,
  parameter int NONCE_SIZE         = 32
) (
  input  logic                                clk,
  input  logic                                n_rst,
  input  logic                                load,
  input  logic                                abort,
  input  logic [NUM_SHABLOCKS*HASH_WIDTH-1:0] digests,
  input  logic [NONCE_SIZE-1:0]               baseNonce,
  input  logic [HASH_WIDTH-1:0]               target,
  output logic                                busy,
  output logic                                done,
  output logic                                found,
  output logic [LOG2_NUM_SHABLOCKS-1:0]       foundIndex,
  output logic [NONCE_SIZE-1:0]               foundNonce
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [LOG2_NUM_SHABLOCKS-1:0] LAST_IDX = LOG2_NUM_SHABLOCKS'(NUM_SHABLOCKS - 1);
  localparam logic [LOG2_NUM_SHABLOCKS-1:0] ONE_IDX  = LOG2_NUM_SHABLOCKS'(1);

  state_t                          state, state_nxt;
  logic [LOG2_NUM_SHABLOCKS-1:0]   idx, idx_nxt;
  logic [HASH_WIDTH-1:0]           bank [NUM_SHABLOCKS];
  logic [NONCE_SIZE-1:0]           base_nonce;
  logic                            busy_nxt;
  logic                            done_nxt;
  logic                            found_nxt;
  logic [LOG2_NUM_SHABLOCKS-1:0]   found_index_nxt;
  logic [NONCE_SIZE-1:0]           found_nonce_nxt;
  logic                            cmp_hit;
  logic                            accept_load;

  // A new batch is only taken when abort is not also asserted.
  assign accept_load = load && !abort;

  // Strict unsigned compare: a digest equal to the target is a miss.
  assign cmp_hit = (bank[idx] < target);

`ifdef SCANNER_PIPE_CMP_EN
  logic                            pipe_valid, pipe_valid_nxt;
  logic                            pipe_hit;
  logic [LOG2_NUM_SHABLOCKS-1:0]   pipe_idx;

  // Pipe stage holding the previous cycle's compare result and its index.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pipe_valid <= 1'b0;
      pipe_hit   <= 1'b0;
      pipe_idx   <= '0;
    end else begin
      pipe_valid <= pipe_valid_nxt;
      pipe_hit   <= cmp_hit;
      pipe_idx   <= idx;
    end
  end
`endif

  // Batch capture: digest bank and base nonce are latched on an accepted load.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_SHABLOCKS; i++) begin
        bank[i] <= '0;
      end
      base_nonce <= '0;
    end else if (accept_load) begin
      for (int i = 0; i < NUM_SHABLOCKS; i++) begin
        bank[i] <= digests[i*HASH_WIDTH +: HASH_WIDTH];
      end
      base_nonce <= baseNonce;
    end
  end

  // State and registered-output update.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      idx        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      found      <= 1'b0;
      foundIndex <= '0;
      foundNonce <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      found      <= found_nxt;
      foundIndex <= found_index_nxt;
      foundNonce <= found_nonce_nxt;
    end
  end

  // Next-state and next-output logic; abort beats load beats scan progress.
  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    busy_nxt        = busy;
    done_nxt        = 1'b0;
    found_nxt       = found;
    found_index_nxt = foundIndex;
    found_nonce_nxt = foundNonce;

    if (abort) begin
      state_nxt       = IDLE;
      idx_nxt         = '0;
      busy_nxt        = 1'b0;
      found_nxt       = 1'b0;
      found_index_nxt = '0;
      found_nonce_nxt = '0;
    end else if (load) begin
      state_nxt       = SCAN;
      idx_nxt         = '0;
      busy_nxt        = 1'b1;
      found_nxt       = 1'b0;
      found_index_nxt = '0;
      found_nonce_nxt = '0;
    end else begin
      case (state)
        SCAN: begin
`ifdef SCANNER_PIPE_CMP_EN
          if (pipe_valid && pipe_hit) begin
            state_nxt       = REPORT;
            busy_nxt        = 1'b0;
            done_nxt        = 1'b1;
            found_nxt       = 1'b1;
            found_index_nxt = pipe_idx;
            found_nonce_nxt = base_nonce + NONCE_SIZE'(pipe_idx);
          end else if (pipe_valid && (pipe_idx == LAST_IDX)) begin
            state_nxt = REPORT;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else if (idx != LAST_IDX) begin
            idx_nxt = idx + ONE_IDX;
          end
`else
          if (cmp_hit) begin
            state_nxt       = REPORT;
            busy_nxt        = 1'b0;
            done_nxt        = 1'b1;
            found_nxt       = 1'b1;
            found_index_nxt = idx;
            found_nonce_nxt = base_nonce + NONCE_SIZE'(idx);
          end else if (idx == LAST_IDX) begin
            state_nxt = REPORT;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt = idx + ONE_IDX;
          end
`endif
        end
        REPORT: begin
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

`ifdef SCANNER_PIPE_CMP_EN
    // Only a compare made in a continuing scan is valid; abort/load flush it.
    pipe_valid_nxt = (state == SCAN) && (state_nxt == SCAN) && !abort && !load;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_sha_result_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha_result_scanner
// Brief    : Directed self-checking bench for sha_result_scanner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha_result_scanner;

  localparam int NUM   = 10;
  localparam int LOG2  = 4;
  localparam int HW    = 256;
  localparam int NW    = 32;
`ifdef SCANNER_PIPE_CMP_EN
  localparam int PIPE  = 1;
`else
  localparam int PIPE  = 0;
`endif

  logic                  clk;
  logic                  n_rst;
  logic                  load;
  logic                  abort;
  logic [NUM*HW-1:0]     digests;
  logic [NW-1:0]         baseNonce;
  logic [HW-1:0]         target;
  logic                  busy;
  logic                  done;
  logic                  found;
  logic [LOG2-1:0]       foundIndex;
  logic [NW-1:0]         foundNonce;

  int vectors;
  int miscompares;

  logic [HW-1:0] tgt_val;
  logic [HW-1:0] win_val;
  logic [HW-1:0] lose_val;

  sha_result_scanner #(
    .NUM_SHABLOCKS      (NUM),
    .LOG2_NUM_SHABLOCKS (LOG2),
    .HASH_WIDTH         (HW),
    .NONCE_SIZE         (NW)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .load       (load),
    .abort      (abort),
    .digests    (digests),
    .baseNonce  (baseNonce),
    .target     (target),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .foundIndex (foundIndex),
    .foundNonce (foundNonce)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill_all(input logic [HW-1:0] v);
    for (int i = 0; i < NUM; i++) digests[i*HW +: HW] = v;
  endtask

  task automatic set_dig(input int i, input logic [HW-1:0] v);
    digests[i*HW +: HW] = v;
  endtask

  // Pulse load across edge E0; returns at the falling edge after E0.
  task automatic do_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Count edges after E0 until done is seen, plus busy cycles and overlap.
  task automatic run_scan(input int max_edges, output int n_edges,
                          output int busy_cycles, output int overlap);
    n_edges = 0;
    busy_cycles = 0;
    overlap = 0;
    while (!done && n_edges < max_edges) begin
      if (busy) busy_cycles++;
      tick();
      n_edges++;
    end
    if (busy && done) overlap++;
  endtask

  // Count done pulses over a window of cycles.
  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done) pulses++;
      tick();
    end
  endtask

  int edges, bcyc, ovl, pulses;

  initial begin
    vectors     = 0;
    miscompares = 0;
    n_rst       = 1'b0;
    load        = 1'b0;
    abort       = 1'b0;
    digests     = '0;
    baseNonce   = '0;
    tgt_val     = 256'h0000FFFF << 224;
    win_val     = 256'h1 << 200;
    lose_val    = '1;
    target      = tgt_val;

    // Reset state
    #12;
    @(negedge clk);
    check("rst_busy",   64'(busy), 64'd0);
    check("rst_done",   64'(done), 64'd0);
    check("rst_found",  64'(found), 64'd0);
    check("rst_fidx",   64'(foundIndex), 64'd0);
    check("rst_fnonce", 64'(foundNonce), 64'd0);
    n_rst = 1'b1;
    tick();

    // Hit mid-batch: digests 4 and 7 win, first one must be reported
    fill_all(lose_val);
    set_dig(4, win_val);
    set_dig(7, win_val);
    baseNonce = 32'h0000_0100;
    do_load();
    check("hit_busy_e0", 64'(busy), 64'd1);
    run_scan(40, edges, bcyc, ovl);
    check("hit_edges",  64'(edges), 64'(5 + PIPE));
    check("hit_busyc",  64'(bcyc), 64'(5 + PIPE));
    check("hit_ovl",    64'(ovl), 64'd0);
    check("hit_found",  64'(found), 64'd1);
    check("hit_fidx",   64'(foundIndex), 64'd4);
    check("hit_fnonce", 64'(foundNonce), 64'h104);
    tick();
    check("hit_pulse1", 64'(done), 64'd0);
    check("hit_hold",   64'(foundNonce), 64'h104);
    check("hit_idle",   64'(busy), 64'd0);

    // Miss with equality at index 2
    fill_all(lose_val);
    set_dig(2, tgt_val);
    baseNonce = 32'h0000_2000;
    do_load();
    check("miss_clr", 64'(found), 64'd0);
    run_scan(40, edges, bcyc, ovl);
    check("miss_edges", 64'(edges), 64'(10 + PIPE));
    check("miss_busyc", 64'(bcyc), 64'(10 + PIPE));
    check("miss_ovl",   64'(ovl), 64'd0);
    check("miss_found", 64'(found), 64'd0);
    count_done(6, pulses);
    check("miss_pulses", 64'(pulses), 64'd1);

    // Nonce wrap
    fill_all(lose_val);
    set_dig(3, win_val);
    baseNonce = 32'hFFFF_FFFE;
    do_load();
    run_scan(40, edges, bcyc, ovl);
    check("wrap_edges",  64'(edges), 64'(4 + PIPE));
    check("wrap_found",  64'(found), 64'd1);
    check("wrap_fidx",   64'(foundIndex), 64'd3);
    check("wrap_fnonce", 64'(foundNonce), 64'h0000_0001);

    // Abort at idx 5 of a scan that would otherwise hit at 8
    fill_all(lose_val);
    set_dig(8, win_val);
    baseNonce = 32'h0000_0500;
    do_load();
    for (int i = 0; i < 5; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy",  64'(busy), 64'd0);
    check("abort_found", 64'(found), 64'd0);
    check("abort_done",  64'(done), 64'd0);
    count_done(14, pulses);
    check("abort_nodone", 64'(pulses), 64'd0);

    // Load while busy: restart with new data hitting at index 0
    fill_all(lose_val);
    set_dig(6, win_val);
    baseNonce = 32'h0000_0600;
    do_load();
    tick();
    tick();
    fill_all(lose_val);
    set_dig(0, win_val);
    baseNonce = 32'h0000_0A00;
    do_load();
    run_scan(40, edges, bcyc, ovl);
    check("reload_edges",  64'(edges), 64'(1 + PIPE));
    check("reload_fidx",   64'(foundIndex), 64'd0);
    check("reload_fnonce", 64'(foundNonce), 64'h0A00);
    tick();
    count_done(14, pulses);
    check("reload_noold", 64'(pulses), 64'd0);
    check("reload_hold",  64'(foundNonce), 64'h0A00);

    // Simultaneous abort and load: abort wins
    fill_all(lose_val);
    set_dig(1, win_val);
    baseNonce = 32'h0000_0700;
    abort = 1'b1;
    load  = 1'b1;
    tick();
    abort = 1'b0;
    load  = 1'b0;
    check("al_busy",  64'(busy), 64'd0);
    check("al_found", 64'(found), 64'd0);
    count_done(14, pulses);
    check("al_nodone", 64'(pulses), 64'd0);
    set_dig(1, lose_val);
    set_dig(2, win_val);
    do_load();
    run_scan(40, edges, bcyc, ovl);
    check("al_next_edges",  64'(edges), 64'(3 + PIPE));
    check("al_next_fnonce", 64'(foundNonce), 64'h0702);

    // Asynchronous reset mid-scan
    tick();
    fill_all(lose_val);
    baseNonce = 32'h0000_0900;
    do_load();
    tick();
    tick();
    check("mid_busy_pre", 64'(busy), 64'd1);
    #2;
    n_rst = 1'b0;
    #1;
    check("arst_busy",   64'(busy), 64'd0);
    check("arst_done",   64'(done), 64'd0);
    check("arst_found",  64'(found), 64'd0);
    check("arst_fnonce", 64'(foundNonce), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    tick();
    check("post_rst_busy", 64'(busy), 64'd0);
    count_done(14, pulses);
    check("post_rst_nodone", 64'(pulses), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
